// File: rtl/pv_adc_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pv_adc_pkg
//  Description : Shared types and constants for the PV ADC SPI reader:
//                state encoding, default parameters and the start-to-valid
//                latency formula.
//  Revision    : 1.0 - initial release
// ============================================================================
package pv_adc_pkg;

    // Default build of the reader.
    localparam int unsigned c_def_data_bits  = 4;
    localparam int unsigned c_def_frame_bits = 8;
    localparam int unsigned c_def_div        = 2;

    // Reader state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Clock cycles from the edge that samples start to the edge that raises valid.
    // The frame spends DIV cycles in SETUP, 2*DIV per bit in SHIFT and DIV in HOLD.
    function automatic int unsigned adc_latency(input int unsigned div,
                                                input int unsigned frame_bits);
        return div * (2 * frame_bits + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pv_adc_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : pv_adc_reader_if
//  Description : Handshake and SPI signal bundle between the PV ADC reader
//                (master modport) and its surroundings (slave modport).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pv_adc_reader_if
    import pv_adc_pkg::*;
#(
    parameter int unsigned DATA_BITS = c_def_data_bits
) ();

    logic                 start;
    logic                 miso;
    logic                 sck;
    logic                 cs;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 busy;
    logic                 overrun;

    // Seen from the reader itself.
    modport master (
        input  start,
        input  miso,
        output sck,
        output cs,
        output data,
        output valid,
        output busy,
        output overrun
    );

    // Seen from the sample strobe, the ADC and the PID core.
    modport slave (
        output start,
        output miso,
        input  sck,
        input  cs,
        input  data,
        input  valid,
        input  busy,
        input  overrun
    );

endinterface
`default_nettype wire

// File: rtl/pv_adc_reader_half_period_tick.sv
`default_nettype none
// ============================================================================
//  Module      : half_period_tick
//  Description : Loadable down-counter producing a one-cycle tick every DIV
//                enabled cycles. Reloads on clear, so the first tick after a
//                clear lands exactly DIV enabled cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module half_period_tick #(
    parameter int unsigned DIV = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_tick
);

    localparam int unsigned            c_cnt_w  = $clog2(DIV + 1);
    localparam logic [c_cnt_w-1:0]     c_reload = c_cnt_w'(DIV);
    localparam logic [c_cnt_w-1:0]     c_one    = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // Tick on the last cycle of each DIV-cycle window; the counter reloads at the same edge.
    assign o_tick = i_enable && (r_cnt == c_one);

    // Count down while enabled, reload on clear or when the window closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= c_reload;
        end else if (i_clear || o_tick) begin
            r_cnt <= c_reload;
        end else if (i_enable) begin
            r_cnt <= r_cnt - c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pv_adc_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pv_adc_reader
//  Description : SPI mode-0 master that reads one framed word from the PV ADC
//                per start pulse and presents its low DATA_BITS with a
//                one-cycle valid strobe for the PID core.
//  Revision    : 1.0 - initial release
// ============================================================================
module pv_adc_reader
    import pv_adc_pkg::*;
#(
    parameter int unsigned DATA_BITS  = c_def_data_bits,
    parameter int unsigned FRAME_BITS = c_def_frame_bits,
    parameter int unsigned DIV        = c_def_div
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pv_adc_reader_if.master bus
);

    localparam int unsigned            c_bit_cnt_w = $clog2(FRAME_BITS + 1);
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(FRAME_BITS);
    localparam logic [c_bit_cnt_w-1:0] c_bit_one   = c_bit_cnt_w'(1);

    state_t                 r_state;
    logic                   r_sck;
    logic                   r_cs;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_overrun;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;

    logic w_tick;
    logic w_tick_clear;
    logic w_tick_enable;
    logic w_frame_done;

    // The half-period timer is held at its reload value while idle so that
    // SETUP, SHIFT and HOLD all start from a full DIV-cycle window.
    assign w_tick_clear  = (r_state == IDLE);
    assign w_tick_enable = (r_state != IDLE);
    assign w_frame_done  = (r_bit_cnt == c_last_bit);

    half_period_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_tick_clear),
        .i_enable (w_tick_enable),
        .o_tick   (w_tick)
    );

    // Frame sequencer: all bus outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_valid   <= 1'b0;
            // A start that lands while a frame is in flight (including the
            // closing HOLD edge) is dropped and flagged one cycle later.
            r_overrun <= bus.start && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state   <= SETUP;
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_sck     <= 1'b0;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_sck) begin
                            // Rising edge: capture miso as the new LSB (MSB-first frame).
                            r_sck     <= 1'b1;
                            r_shift   <= (r_shift << 1) | FRAME_BITS'(bus.miso);
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                        end else begin
                            r_sck <= 1'b0;
                            if (w_frame_done) begin
                                r_state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        // ADC word is right-justified: keep only the low bits.
                        r_state <= IDLE;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_data  <= r_shift[DATA_BITS-1:0];
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sck     = r_sck;
    assign bus.cs      = r_cs;
    assign bus.data    = r_data;
    assign bus.valid   = r_valid;
    assign bus.busy    = r_busy;
    assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/pv_adc_reader.md
# pv_adc_reader

SPI master that fetches the process variable from the external ADC for the PID controller. A one-cycle `start` pulse from the sample-rate strobe launches one framed read: `cs` is driven low, `FRAME_BITS` bits are clocked in MSB-first, and `cs` is released. When `cs` is released, the low `DATA_BITS` of the frame are presented on `data` with a one-cycle `valid` pulse. That pulse is the PID core's sample strobe.

## Interface
- `DATA_BITS`, default 4: width of the PV word delivered to the PID core.
- `FRAME_BITS`, default 8: SPI bits per transaction. Must satisfy `FRAME_BITS >= DATA_BITS`.
- `DIV`, default 2: `sck` half-period in `clk` cycles. Must satisfy `DIV >= 1`.
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. 0 resets the block; deassertion must be synchronous to `clk` at the system level.
- `start`, input, 1: launches one read when high for a cycle while idle.
- `miso`, input, 1: serial data from the ADC.
- `sck`, output, 1: SPI clock. Idles low; data is sampled on the rising edge (mode 0).
- `cs`, output, 1: active-low chip select. Idles high.
- `data`, output, `DATA_BITS`: last captured PV. Held between frames.
- `valid`, output, 1: one-cycle pulse when `data` updates.
- `busy`, output, 1: high from the accepted `start` until `valid`.
- `overrun`, output, 1: one-cycle pulse when `start` arrives while busy.

## Operation
- All outputs are registered. Reset values: `sck`=0, `cs`=1, `data`=0, `valid`=0, `busy`=0, `overrun`=0; the state machine returns to IDLE.
- IDLE: `start`=1 moves to SETUP, drives `cs`=0 and `busy`=1, clears the shift register and counters.
- SETUP: hold `cs` low, `sck` low for `DIV` cycles, then go to SHIFT.
- SHIFT: the half-period counter expires every `DIV` cycles and toggles `sck`.
  - On a 0→1 toggle, shift `miso` into the LSB of the shift register (MSB-first frame).
  - After the `FRAME_BITS`-th rising edge, the next falling edge returns `sck` to 0 and moves to HOLD.
- HOLD: keep `cs` low for `DIV` cycles, then go back to IDLE. On that transition, in the same edge:
  - `cs`=1, `busy`=0, `valid`=1;
  - `data` takes `shift[DATA_BITS-1:0]`; the upper frame bits are discarded (the ADC word is right-justified).
- `start` while not in IDLE is ignored and pulses `overrun` in the following cycle. The current frame is unaffected.
- `start` in the same cycle that `valid` pulses is also ignored with `overrun`. The block is back in IDLE only from the next cycle.
- Asynchronous reset mid-frame aborts immediately: `cs` goes high and `sck` low with no extra edge. `data` returns to 0 and no `valid` is produced.
- Counter widths: `$clog2(DIV+1)` for the half-period counter, `$clog2(FRAME_BITS+1)` for the bit counter. No wrap-around is possible in legal configurations.

## Timing
- With `start` sampled at edge k:
  - `cs` falls at edge k.
  - First `sck` rise at edge k+2·`DIV`.
  - `valid` is high and `cs` rises at edge k+`DIV`·(2·`FRAME_BITS`+2).
- Defaults: `valid` arrives 36 cycles after `start`. `sck` period is 4 `clk` cycles.
- `miso` is sampled at the same `clk` edge at which `sck` is driven high. The ADC must hold data stable for the whole preceding low half-period.
- Minimum back-to-back spacing: `start` at edge k+`DIV`·(2·`FRAME_BITS`+2)+1, which gives `cs` high for at least one cycle between frames.

## Structure
- Shared package `pv_adc_pkg`:
  - state encoding constants IDLE/SETUP/SHIFT/HOLD (2-bit);
  - default parameter constants;
  - the latency formula as a constant function, used by the bench.
- One sub-module, `half_period_tick`: a loadable down-counter that emits a one-cycle tick every `DIV` cycles while enabled and reloads on `clear`. It is reused for the SETUP, SHIFT and HOLD timing.

## Test plan
- Reset and idle: hold `reset`=0 for 3 cycles, then release with `start` low for 50 cycles → `cs`=1, `sck`=0, `data`=0, and `valid`/`busy`/`overrun` all 0 throughout.
- Basic read (defaults): ADC model returns frame 8'hA7 MSB-first; pulse `start` → exactly 8 `sck` rising edges, `valid` at +36 cycles, `data`=4'h7, `cs` low for exactly 36 cycles.
- Overrun: pulse `start`, then pulse `start` again 10 cycles later and again in the `valid` cycle → two `overrun` pulses, a single `valid`, and a frame identical to the basic read.
- Reset mid-frame: assert `reset` after the 3rd `sck` rising edge → `cs`=1 and `sck`=0 within the same cycle; `data`=0; no `valid`; the next `start` produces a clean read of 8'h3C → `data`=4'hC.
- Parameter sweep: `DIV`=1 with `FRAME_BITS`=4, and `DIV`=3 with `FRAME_BITS`=12 and `DATA_BITS`=10 → `valid` latency equals `DIV`·(2·`FRAME_BITS`+2) (10 and 78); captured data matches the low bits of a random frame.
- Back-to-back: `start` at the minimum spacing for 20 frames of random data → all 20 `valid` pulses, no `overrun`, `cs` high for ≥1 cycle between frames, each `data` correct.
